// File: rtl/rx_frame_buffer.sv
// rtl/rx_frame_buffer.sv - double-buffered multi-channel Rx frame memory with interleaved HDMI pixel readout
// One bank fills from NUM_CH write lanes while the other bank is read out as 24-bit pixels on a clock-enable.
module rx_frame_buffer #(
  parameter int NUM_CH      = 4,
  parameter int DEPTH       = 38400,
  parameter int ADDR_W      = 16,
  parameter int DIV         = 5,
  parameter int EXPAND_MODE = 0
) (
  input  logic                   Cclk,
  input  logic                   rst,
  input  logic                   frame_sync,
  input  logic [NUM_CH-1:0]      wr_valid,
  input  logic [12*NUM_CH-1:0]   wr_data,
  output logic [NUM_CH-1:0]      wr_ovf,
  output logic                   wr_bank,
  output logic                   pix_ce,
  input  logic                   vsync_n,
  input  logic                   de,
  output logic [23:0]            hdmi_data,
  output logic                   hdmi_valid
);

  localparam int LOG_CH = $clog2(NUM_CH);
  localparam int CH_W   = (NUM_CH > 1) ? LOG_CH : 1;
  localparam int PC_W   = $clog2(NUM_CH * DEPTH);
  localparam int MI_W   = $clog2(DEPTH);
  localparam int DIV_W  = $clog2(DIV);
  localparam logic [PC_W-1:0]   PC_LAST = PC_W'(NUM_CH * DEPTH - 1);
  localparam logic [ADDR_W:0]   WA_FULL = (ADDR_W + 1)'(DEPTH);
  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(DIV - 1);

  logic [DIV_W-1:0]    div_cnt;
  logic [ADDR_W:0]     wadr [NUM_CH];
  logic                rd_bank;
  logic [PC_W-1:0]     pc;
  logic                rd_en;
  logic [MI_W-1:0]     rd_addr;
  logic [CH_W-1:0]     rd_sel;
  logic [12*NUM_CH-1:0] rd_all;
  logic                s1_valid;
  logic                s1_blank;
  logic [CH_W-1:0]     s1_sel;

  function automatic logic [7:0] nib2byte(input logic [3:0] n);
    return (EXPAND_MODE != 0) ? {n, n} : {n, 4'hF};
  endfunction

  always_ff @(posedge Cclk or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
      pix_ce  <= 1'b0;
    end else begin
      pix_ce  <= (div_cnt == '0);
      div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
    end
  end

  // wadr is one bit wider than ADDR_W so it can sit at DEPTH even when DEPTH == 2**ADDR_W
  always_ff @(posedge Cclk or posedge rst) begin
    if (rst) begin
      wr_bank <= 1'b0;
      wr_ovf  <= '0;
      for (int c = 0; c < NUM_CH; c++) wadr[c] <= '0;
    end else begin
      if (frame_sync) wr_bank <= ~wr_bank;
      for (int c = 0; c < NUM_CH; c++) begin
        if (frame_sync) begin
          wadr[c]   <= wr_valid[c] ? (ADDR_W + 1)'(1) : '0;
          wr_ovf[c] <= 1'b0;
        end else if (wr_valid[c]) begin
          if (wadr[c] < WA_FULL) wadr[c] <= wadr[c] + 1'b1;
          else                   wr_ovf[c] <= 1'b1;
        end
      end
    end
  end

  assign rd_en   = pix_ce && de && vsync_n;
  assign rd_addr = MI_W'(pc >> LOG_CH);
  assign rd_sel  = (NUM_CH > 1) ? CH_W'(pc) : '0;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [11:0]     mem [2][DEPTH];
    logic [11:0]     q;
    logic            we;
    logic            wb;
    logic [MI_W-1:0] wa;

    // a word coincident with frame_sync lands at address 0 of the bank being switched to
    assign we = wr_valid[g] && (frame_sync || (wadr[g] < WA_FULL));
    assign wb = wr_bank ^ frame_sync;
    assign wa = frame_sync ? '0 : wadr[g][MI_W-1:0];

    always_ff @(posedge Cclk) begin
      if (we)    mem[wb][wa] <= wr_data[12*g +: 12];
      if (rd_en) q <= mem[rd_bank][rd_addr];
    end

    assign rd_all[12*g +: 12] = q;
  end

  always_ff @(posedge Cclk or posedge rst) begin
    if (rst) begin
      rd_bank    <= 1'b1;
      pc         <= '0;
      s1_valid   <= 1'b0;
      s1_blank   <= 1'b0;
      s1_sel     <= '0;
      hdmi_data  <= '0;
      hdmi_valid <= 1'b0;
    end else begin
      // the read bank only follows the write bank during vertical blank, so a frame never tears
      if (!vsync_n) begin
        rd_bank  <= ~wr_bank;
        pc       <= '0;
        s1_valid <= 1'b0;
      end else begin
        s1_valid <= pix_ce;
        if (pix_ce) begin
          s1_blank <= ~de;
          s1_sel   <= rd_sel;
          if (de) pc <= (pc == PC_LAST) ? '0 : pc + 1'b1;
        end
      end
      hdmi_valid <= s1_valid;
      if (s1_valid) begin
        if (s1_blank) hdmi_data <= '0;
        else hdmi_data <= {nib2byte(rd_all[12*s1_sel + 8 +: 4]),
                           nib2byte(rd_all[12*s1_sel + 4 +: 4]),
                           nib2byte(rd_all[12*s1_sel +: 4])};
      end
    end
  end

endmodule
